// File: rtl/ps2_rx_fifo.sv
`default_nettype none
// ============================================================================
// ps2_rx_fifo : synchronous PS/2 receiver with E0/F0 decode and FWFT event FIFO
// Revision    : 1.0
// ============================================================================
module ps2_rx_fifo #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FIFO_DEPTH     = 4,
    parameter bit REPORT_BREAK   = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        kb_clk,
    input  logic                        kb_data,
    output logic [7:0]                  data,
    output logic                        data_break,
    output logic                        data_ext,
    output logic                        data_valid,
    input  logic                        data_ready,
    output logic                        frame_err,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic                   clk_prev;
    logic                   clk_s;
    logic                   dat_s;
    logic                   fall;

    // Chains preset to idle-high so releasing reset never looks like an edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_sync <= '1;
            dat_sync <= '1;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], kb_clk};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], kb_data};
            clk_prev <= clk_s;
        end
    end

    assign clk_s = clk_sync[SYNC_STAGES-1];
    assign dat_s = dat_sync[SYNC_STAGES-1];
    assign fall  = clk_prev & ~clk_s;

    logic [1:0]    state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          parity;
    logic [WW-1:0] wd_cnt;
    logic          timeout;
    logic          start_err;
    logic          frame_good;
    logic          frame_ok;
    logic          stop_err;

    assign timeout    = (state != S_IDLE) && !fall && (wd_cnt == WW'(TIMEOUT_CYCLES - 1));
    assign start_err  = fall && (state == S_IDLE) && dat_s;
    assign frame_good = dat_s && ((^shreg) ^ parity);
    assign frame_ok   = fall && (state == S_STOP) && frame_good;
    assign stop_err   = fall && (state == S_STOP) && !frame_good;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            parity  <= 1'b0;
            wd_cnt  <= '0;
        end else begin
            if (fall || state == S_IDLE) wd_cnt <= '0;
            else                         wd_cnt <= wd_cnt + WW'(1);

            if (timeout) begin
                state <= S_IDLE;
            end else if (fall) begin
                case (state)
                    S_IDLE: begin
                        if (!dat_s) begin
                            state   <= S_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    S_DATA: begin
                        shreg   <= {dat_s, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= S_PARITY;
                    end
                    S_PARITY: begin
                        parity <= dat_s;
                        state  <= S_STOP;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    logic       ext_pend;
    logic       brk_pend;
    logic       is_prefix;
    logic       push;
    logic [9:0] push_ev;

    assign is_prefix = (shreg == 8'hE0) || (shreg == 8'hF0);
    assign push_ev   = {ext_pend, brk_pend, shreg};
    assign push      = frame_ok && !is_prefix && !(brk_pend && !REPORT_BREAK);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
        end else if (stop_err || timeout) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
        end else if (frame_ok) begin
            if (shreg == 8'hE0) begin
                ext_pend <= 1'b1;
            end else if (shreg == 8'hF0) begin
                brk_pend <= 1'b1;
            end else begin
                ext_pend <= 1'b0;
                brk_pend <= 1'b0;
            end
        end
    end

    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_next;
    logic          full;
    logic          pop;
    logic          push_ok;
    logic [CW-1:0] count_next;

    assign full    = (fifo_count == CW'(FIFO_DEPTH));
    assign pop     = data_valid && data_ready;
    assign push_ok = push && (!full || pop);
    assign rd_next = pop ? rd_ptr + AW'(1) : rd_ptr;

    always_comb begin
        count_next = fifo_count;
        if (push_ok && !pop)      count_next = fifo_count + CW'(1);
        else if (pop && !push_ok) count_next = fifo_count - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_ev;
    end

    // Head is registered so it holds its last value once the FIFO drains;
    // it takes the incoming event when that event becomes the new head.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
            data       <= '0;
            data_break <= 1'b0;
            data_ext   <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            rd_ptr     <= rd_next;
            fifo_count <= count_next;
            data_valid <= (count_next != '0);
            frame_err  <= start_err | stop_err | timeout;
            overflow   <= push && full && !pop;
            if (count_next != '0) begin
                if (fifo_count == CW'(pop)) {data_ext, data_break, data} <= push_ev;
                else                        {data_ext, data_break, data} <= mem[rd_next];
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_ps2_rx_fifo.sv
`default_nettype none
// ============================================================================
// tb_ps2_rx_fifo : scoreboard bench for the PS/2 receiver and event FIFO
// Revision       : 1.0
// ============================================================================
module tb_ps2_rx_fifo;
    localparam int TMO = 200;

    logic       clk        = 1'b0;
    logic       reset      = 1'b0;
    logic       kb_clk     = 1'b1;
    logic       kb_data    = 1'b1;
    logic       data_ready = 1'b0;
    logic       nb_ready   = 1'b1;

    logic [7:0] data;
    logic       data_break, data_ext, data_valid, frame_err, overflow;
    logic [2:0] fifo_count;
    logic [7:0] nb_data;
    logic       nb_break, nb_ext, nb_valid, nb_err, nb_ovf;
    logic [2:0] nb_count;

    always #5 clk = ~clk;

    ps2_rx_fifo #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TMO), .FIFO_DEPTH(4), .REPORT_BREAK(1'b1)) dut (
        .clk(clk), .reset(reset), .kb_clk(kb_clk), .kb_data(kb_data),
        .data(data), .data_break(data_break), .data_ext(data_ext),
        .data_valid(data_valid), .data_ready(data_ready),
        .frame_err(frame_err), .overflow(overflow), .fifo_count(fifo_count)
    );

    ps2_rx_fifo #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TMO), .FIFO_DEPTH(4), .REPORT_BREAK(1'b0)) dut_nb (
        .clk(clk), .reset(reset), .kb_clk(kb_clk), .kb_data(kb_data),
        .data(nb_data), .data_break(nb_break), .data_ext(nb_ext),
        .data_valid(nb_valid), .data_ready(nb_ready),
        .frame_err(nb_err), .overflow(nb_ovf), .fifo_count(nb_count)
    );

    logic [9:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int err_cnt = 0, ovf_cnt = 0, valid_cycles = 0, nb_valid_cycles = 0;

    // Scoreboard side: every accepted head is compared with the oldest expectation.
    always @(negedge clk) begin
        if (reset) begin
            if (frame_err)  err_cnt++;
            if (overflow)   ovf_cnt++;
            if (data_valid) valid_cycles++;
            if (nb_valid)   nb_valid_cycles++;
            if (data_valid && data_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL pop_unexpected: got ext=%b brk=%b data=%h, required no event",
                             data_ext, data_break, data);
                end else begin
                    logic [9:0] e;
                    e = exp_q.pop_front();
                    if ({data_ext, data_break, data} !== e)
                        $display("FAIL pop_event: got ext=%b brk=%b data=%h, required ext=%b brk=%b data=%h",
                                 data_ext, data_break, data, e[9], e[8], e[7:0]);
                    else
                        n_pass++;
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        err_cnt = 0; ovf_cnt = 0; valid_cycles = 0; nb_valid_cycles = 0;
    endtask

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            kb_data = f[i];
            cycles(5);
            kb_clk = 1'b0;
            cycles(10);
            kb_clk = 1'b1;
            cycles(5);
        end
        kb_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par);
        logic p;
        p = (~^b) ^ bad_par;
        send_bits({1'b1, p, b, 1'b0}, 11);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        cycles(4);
        n_checks++;
        if ({data_ext, data_break, data} !== 10'h0)
            $display("FAIL reset_head: got %h, required 000", {data_ext, data_break, data});
        else n_pass++;
        n_checks++;
        if (fifo_count !== 3'd0) $display("FAIL reset_count: got %0d, required 0", fifo_count);
        else n_pass++;
        n_checks++;
        if (data_valid !== 1'b0) $display("FAIL reset_valid: got %b, required 0", data_valid);
        else n_pass++;
        n_checks++;
        if ({frame_err, overflow} !== 2'b00)
            $display("FAIL reset_pulses: got %b, required 00", {frame_err, overflow});
        else n_pass++;
        reset = 1'b1;
        clear_counts();
        cycles(6);
        n_checks++;
        if (err_cnt !== 0) $display("FAIL release_no_edge: got %0d errors, required 0", err_cnt);
        else n_pass++;
    endtask

    task automatic test_make();
        data_ready = 1'b1;
        clear_counts();
        exp_q.push_back({2'b00, 8'h1C});
        send_frame(8'h1C, 1'b0);
        cycles(8);
        n_checks++;
        if (exp_q.size() !== 0) $display("FAIL make_missing: got %0d pending, required 0", exp_q.size());
        else n_pass++;
        n_checks++;
        if (valid_cycles !== 1) $display("FAIL make_valid_len: got %0d cycles, required 1", valid_cycles);
        else n_pass++;
        n_checks++;
        if (err_cnt !== 0) $display("FAIL make_err: got %0d errors, required 0", err_cnt);
        else n_pass++;
    endtask

    task automatic test_break();
        clear_counts();
        exp_q.push_back({2'b01, 8'h1C});
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b0);
        cycles(8);
        n_checks++;
        if (exp_q.size() !== 0) $display("FAIL break_missing: got %0d pending, required 0", exp_q.size());
        else n_pass++;
        n_checks++;
        if (valid_cycles !== 1) $display("FAIL break_events: got %0d cycles, required 1", valid_cycles);
        else n_pass++;
        n_checks++;
        if (nb_valid_cycles !== 0) $display("FAIL nobreak_queued: got %0d cycles, required 0", nb_valid_cycles);
        else n_pass++;
        n_checks++;
        if (nb_count !== 3'd0) $display("FAIL nobreak_count: got %0d, required 0", nb_count);
        else n_pass++;
    endtask

    task automatic test_ext();
        clear_counts();
        exp_q.push_back({2'b11, 8'h75});
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h75, 1'b0);
        exp_q.push_back({2'b00, 8'h75});
        send_frame(8'h75, 1'b0);
        exp_q.push_back({2'b10, 8'h1C});
        send_frame(8'hE0, 1'b0);
        send_frame(8'hE0, 1'b0);
        send_frame(8'h1C, 1'b0);
        cycles(8);
        n_checks++;
        if (exp_q.size() !== 0) $display("FAIL ext_missing: got %0d pending, required 0", exp_q.size());
        else n_pass++;
        n_checks++;
        if (valid_cycles !== 3) $display("FAIL ext_events: got %0d cycles, required 3", valid_cycles);
        else n_pass++;
    endtask

    task automatic test_parity();
        clear_counts();
        send_frame(8'h1C, 1'b1);
        cycles(8);
        n_checks++;
        if (err_cnt !== 1) $display("FAIL parity_err: got %0d pulses, required 1", err_cnt);
        else n_pass++;
        n_checks++;
        if (valid_cycles !== 0) $display("FAIL parity_queued: got %0d cycles, required 0", valid_cycles);
        else n_pass++;
        exp_q.push_back({2'b00, 8'h1C});
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b1);
        send_frame(8'h1C, 1'b0);
        cycles(8);
        n_checks++;
        if (exp_q.size() !== 0) $display("FAIL parity_flags: got %0d pending, required 0", exp_q.size());
        else n_pass++;
        n_checks++;
        if (err_cnt !== 2) $display("FAIL parity_err2: got %0d pulses, required 2", err_cnt);
        else n_pass++;
    endtask

    task automatic test_timeout();
        clear_counts();
        send_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 5);
        cycles(TMO / 2);
        n_checks++;
        if (err_cnt !== 0) $display("FAIL timeout_early: got %0d pulses, required 0", err_cnt);
        else n_pass++;
        cycles(TMO);
        n_checks++;
        if (err_cnt !== 1) $display("FAIL timeout_err: got %0d pulses, required 1", err_cnt);
        else n_pass++;
        exp_q.push_back({2'b00, 8'h1C});
        send_frame(8'h1C, 1'b0);
        cycles(8);
        n_checks++;
        if (exp_q.size() !== 0) $display("FAIL timeout_recover: got %0d pending, required 0", exp_q.size());
        else n_pass++;
        n_checks++;
        if (err_cnt !== 1) $display("FAIL timeout_err_after: got %0d pulses, required 1", err_cnt);
        else n_pass++;
    endtask

    task automatic test_overflow();
        logic [7:0] codes [5];
        codes = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E};
        data_ready = 1'b0;
        clear_counts();
        for (int i = 0; i < 5; i++) begin
            if (i < 4) exp_q.push_back({2'b00, codes[i]});
            send_frame(codes[i], 1'b0);
            cycles(4);
            if (i == 3) begin
                n_checks++;
                if (ovf_cnt !== 0) $display("FAIL ovf_early: got %0d pulses, required 0", ovf_cnt);
                else n_pass++;
            end
        end
        n_checks++;
        if (fifo_count !== 3'd4) $display("FAIL ovf_count: got %0d, required 4", fifo_count);
        else n_pass++;
        n_checks++;
        if (ovf_cnt !== 1) $display("FAIL ovf_pulse: got %0d pulses, required 1", ovf_cnt);
        else n_pass++;
        n_checks++;
        if (data !== 8'h16 || data_valid !== 1'b1)
            $display("FAIL ovf_head: got data=%h valid=%b, required data=16 valid=1", data, data_valid);
        else n_pass++;
        data_ready = 1'b1;
        cycles(10);
        n_checks++;
        if (exp_q.size() !== 0) $display("FAIL drain_missing: got %0d pending, required 0", exp_q.size());
        else n_pass++;
        n_checks++;
        if (data_valid !== 1'b0 || fifo_count !== 3'd0)
            $display("FAIL drain_empty: got valid=%b count=%0d, required valid=0 count=0", data_valid, fifo_count);
        else n_pass++;
    endtask

    task automatic test_reset_midframe();
        data_ready = 1'b0;
        clear_counts();
        send_frame(8'h45, 1'b0);
        send_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 3);
        reset = 1'b0;
        cycles(2);
        exp_q.delete();
        n_checks++;
        if (fifo_count !== 3'd0 || data_valid !== 1'b0)
            $display("FAIL midreset_flush: got count=%0d valid=%b, required 0/0", fifo_count, data_valid);
        else n_pass++;
        reset = 1'b1;
        cycles(4);
        data_ready = 1'b1;
        exp_q.push_back({2'b00, 8'h2E});
        send_frame(8'h2E, 1'b0);
        cycles(8);
        n_checks++;
        if (exp_q.size() !== 0) $display("FAIL midreset_recover: got %0d pending, required 0", exp_q.size());
        else n_pass++;
        n_checks++;
        if (err_cnt !== 0) $display("FAIL midreset_err: got %0d pulses, required 0", err_cnt);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_make();
        test_break();
        test_ext();
        test_parity();
        test_timeout();
        test_overflow();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
